// File: rtl/pe_dot_accum_pkg.sv
// Shared configuration, width typedefs and the saturating-add helper for the
// PE dot-product accumulator.
package pe_dot_accum_pkg;

  typedef struct packed {
    int num_features;
    int num_filters;
    int dot_size;
    int feature_width;
    int filter_width;
    int dot_latency;
    int acc_width;
  } pe_dot_accum_cfg_t;

  localparam pe_dot_accum_cfg_t PE_DOT_ACCUM_CFG_DEFAULT = '{
    num_features:  2,
    num_filters:   2,
    dot_size:      4,
    feature_width: 8,
    filter_width:  8,
    dot_latency:   3,
    acc_width:     32
  };

  localparam int DEF_DOT_W = PE_DOT_ACCUM_CFG_DEFAULT.feature_width
                           + PE_DOT_ACCUM_CFG_DEFAULT.filter_width
                           + $clog2(PE_DOT_ACCUM_CFG_DEFAULT.dot_size);

  typedef logic signed [DEF_DOT_W-1:0]                          dot_sum_t;
  typedef logic signed [PE_DOT_ACCUM_CFG_DEFAULT.acc_width-1:0] acc_t;

  // Result of a saturating add: clamped value (low 'width' bits meaningful)
  // plus a flag telling whether clamping happened.
  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } sat_res_t;

  // Operands are sign-extended to 64 bits by the caller; width must be <= 62
  // so the raw sum cannot wrap before it is clamped.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    sum   = a + b;
    hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.sat = 1'b0;
    r.val = sum;
    if (sum > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (sum < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_dot_accum_lane.sv
// One feature x filter lane: signed products registered in the first stage,
// summed at full precision, then delayed so the total depth is DOT_LATENCY.
module pe_dot_lane #(
  parameter int DOT_SIZE      = 4,
  parameter int FEATURE_WIDTH = 8,
  parameter int FILTER_WIDTH  = 8,
  parameter int DOT_LATENCY   = 3,
  parameter int DOT_W         = FEATURE_WIDTH + FILTER_WIDTH + $clog2(DOT_SIZE)
) (
  input  logic                                    clock,
  input  logic                                    en_i,
  input  logic [DOT_SIZE-1:0][FEATURE_WIDTH-1:0]  feature_i,
  input  logic [DOT_SIZE-1:0][FILTER_WIDTH-1:0]   filter_i,
  output logic [DOT_W-1:0]                        dot_o
);

  localparam int PROD_W = FEATURE_WIDTH + FILTER_WIDTH;

  logic [DOT_SIZE-1:0][PROD_W-1:0] prod;

  function automatic logic [DOT_W-1:0] tree_sum(input logic [DOT_SIZE-1:0][PROD_W-1:0] p);
    logic signed [DOT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < DOT_SIZE; i++) begin
      acc = acc + DOT_W'($signed(p[i]));
    end
    return acc;
  endfunction

  // Element-wise signed products, both operands sign-extended to product width.
  always_comb begin
    prod = '0;
    for (int i = 0; i < DOT_SIZE; i++) begin
      prod[i] = PROD_W'($signed(feature_i[i])) * PROD_W'($signed(filter_i[i]));
    end
  end

  if (DOT_LATENCY == 1) begin : g_lat1
    logic [DOT_W-1:0] dot_q;

    // Single stage: multiply and sum in one cycle.
    always_ff @(posedge clock) begin
      if (en_i) dot_q <= tree_sum(prod);
    end

    assign dot_o = dot_q;
  end else begin : g_latn
    logic [DOT_SIZE-1:0][PROD_W-1:0] prod_q;
    logic [DOT_W-1:0]                sum_q [DOT_LATENCY-1];

    // Product register, sum register, then plain delay stages; all freeze on stall.
    always_ff @(posedge clock) begin
      if (en_i) begin
        prod_q   <= prod;
        sum_q[0] <= tree_sum(prod_q);
        for (int k = 1; k < DOT_LATENCY - 1; k++) begin
          sum_q[k] <= sum_q[k-1];
        end
      end
    end

    assign dot_o = sum_q[DOT_LATENCY-2];
  end

endmodule

// File: rtl/pe_dot_accum.sv
// PE dot-product engine: NUM_FEATURES x NUM_FILTERS pipelined dot products per
// beat, accumulated with saturation across first..last delimited vectors, with
// a valid/ready handshake on both sides and sticky per-lane overflow flags.
module pe_dot_accum
  import pe_dot_accum_pkg::*;
#(
  parameter int NUM_FEATURES  = PE_DOT_ACCUM_CFG_DEFAULT.num_features,
  parameter int NUM_FILTERS   = PE_DOT_ACCUM_CFG_DEFAULT.num_filters,
  parameter int DOT_SIZE      = PE_DOT_ACCUM_CFG_DEFAULT.dot_size,
  parameter int FEATURE_WIDTH = PE_DOT_ACCUM_CFG_DEFAULT.feature_width,
  parameter int FILTER_WIDTH  = PE_DOT_ACCUM_CFG_DEFAULT.filter_width,
  parameter int DOT_LATENCY   = PE_DOT_ACCUM_CFG_DEFAULT.dot_latency,
  parameter int ACC_WIDTH     = PE_DOT_ACCUM_CFG_DEFAULT.acc_width
) (
  input  logic                                                    clock,
  input  logic                                                    resetn,
  input  logic                                                    i_valid,
  output logic                                                    o_ready,
  input  logic                                                    i_first,
  input  logic                                                    i_last,
  input  logic [NUM_FEATURES-1:0][DOT_SIZE-1:0][FEATURE_WIDTH-1:0] i_feature,
  input  logic [NUM_FILTERS-1:0][DOT_SIZE-1:0][FILTER_WIDTH-1:0]   i_filter,
  output logic                                                    o_valid,
  input  logic                                                    i_ready,
  output logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0][ACC_WIDTH-1:0]  o_result,
  output logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0]                 o_overflow
);

  localparam int DOT_W = FEATURE_WIDTH + FILTER_WIDTH + $clog2(DOT_SIZE);
  localparam int L     = DOT_LATENCY;

  logic                                                    pipe_en;
  logic [L-1:0]                                            vld_q;
  logic [L-1:0]                                            first_q;
  logic [L-1:0]                                            last_q;
  logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0][DOT_W-1:0]     dot;
  logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
  logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0][ACC_WIDTH-1:0] res_q, res_d;
  logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0]                ovf_q, ovf_d;
  logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0]                res_ovf_q, res_ovf_d;
  logic                                                    o_valid_q, o_valid_d;
  logic signed [63:0]                                      base;
  sat_res_t                                                sr;

  // A held, unaccepted result stalls every stage, including the dot pipeline.
  assign pipe_en = !(o_valid_q && !i_ready);
  assign o_ready = pipe_en;

  for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
    for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_filt
      pe_dot_lane #(
        .DOT_SIZE      (DOT_SIZE),
        .FEATURE_WIDTH (FEATURE_WIDTH),
        .FILTER_WIDTH  (FILTER_WIDTH),
        .DOT_LATENCY   (DOT_LATENCY),
        .DOT_W         (DOT_W)
      ) u_lane (
        .clock     (clock),
        .en_i      (pipe_en),
        .feature_i (i_feature[f]),
        .filter_i  (i_filter[g]),
        .dot_o     (dot[f][g])
      );
    end
  end

  // Valid/first/last flags travel alongside the lane data.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (pipe_en) begin
      vld_q[0]   <= i_valid;
      first_q[0] <= i_first;
      last_q[0]  <= i_last;
      for (int k = 1; k < L; k++) begin
        vld_q[k]   <= vld_q[k-1];
        first_q[k] <= first_q[k-1];
        last_q[k]  <= last_q[k-1];
      end
    end
  end

  // Saturating accumulate, sticky overflow, and result hand-off.
  // A first beat also goes through the clamp so an accumulator narrower than
  // the dot width saturates instead of wrapping.
  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    o_valid_d = o_valid_q;
    base      = '0;
    sr        = '0;
    if (pipe_en) begin
      // With pipe_en high a held result is being accepted this cycle.
      if (o_valid_q) begin
        o_valid_d = 1'b0;
        res_d     = '0;
        res_ovf_d = '0;
      end
      if (vld_q[L-1]) begin
        for (int f = 0; f < NUM_FEATURES; f++) begin
          for (int g = 0; g < NUM_FILTERS; g++) begin
            base        = first_q[L-1] ? 64'sd0 : 64'($signed(acc_q[f][g]));
            sr          = sat_add(base, 64'($signed(dot[f][g])), ACC_WIDTH);
            acc_d[f][g] = sr.val[ACC_WIDTH-1:0];
            ovf_d[f][g] = (first_q[L-1] ? 1'b0 : ovf_q[f][g]) | sr.sat;
          end
        end
        if (last_q[L-1]) begin
          res_d     = acc_d;
          res_ovf_d = ovf_d;
          o_valid_d = 1'b1;
        end
      end
    end
  end

  // Accumulator and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc_q     <= '0;
      ovf_q     <= '0;
      res_q     <= '0;
      res_ovf_q <= '0;
      o_valid_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_valid    = o_valid_q;
  assign o_result   = res_q;
  assign o_overflow = res_ovf_q;

endmodule
